// File: rtl/counter60_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter60_display : BCD seconds counter multiplexed onto a 4-digit       |
// |                     active-low 7-segment display.                        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module counter60_display #(
  parameter int COUNT_MAX       = 59,
  parameter bit LEAD_ZERO_BLANK = 1'b0
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       sec_in,
  input  logic       scan_in,
  input  logic       en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       wrap
);

  localparam logic [3:0] c_max_tens = 4'(COUNT_MAX / 10);
  localparam logic [3:0] c_max_ones = 4'(COUNT_MAX % 10);

  logic       r_sec_q;
  logic       r_scan_q;
  logic [3:0] r_ones;
  logic [3:0] r_tens;
  logic [1:0] r_idx;
  logic       r_wrap;
  logic [3:0] r_an;
  logic [6:0] r_seg;

  logic       w_sec_rise;
  logic       w_scan_rise;
  logic       w_at_max;
  logic [3:0] w_an;
  logic [6:0] w_seg;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'b1000000;
      4'd1:    font = 7'b1111001;
      4'd2:    font = 7'b0100100;
      4'd3:    font = 7'b0110000;
      4'd4:    font = 7'b0011001;
      4'd5:    font = 7'b0010010;
      4'd6:    font = 7'b0000010;
      4'd7:    font = 7'b1111000;
      4'd8:    font = 7'b0000000;
      4'd9:    font = 7'b0010000;
      default: font = 7'b1111111;
    endcase
  endfunction

  assign w_sec_rise  = sec_in  & ~r_sec_q;
  assign w_scan_rise = scan_in & ~r_scan_q;
  assign w_at_max    = (r_tens == c_max_tens) && (r_ones == c_max_ones);

  // Edge-detect history resets high so a level already high at release is ignored
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_sec_q  <= 1'b1;
      r_scan_q <= 1'b1;
    end else begin
      r_sec_q  <= sec_in;
      r_scan_q <= scan_in;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_ones <= 4'd0;
      r_tens <= 4'd0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_sec_rise && en) begin
        if (w_at_max) begin
          r_ones <= 4'd0;
          r_tens <= 4'd0;
          r_wrap <= 1'b1;
        end else if (r_ones == 4'd9) begin
          r_ones <= 4'd0;
          r_tens <= r_tens + 4'd1;
        end else begin
          r_ones <= r_ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_idx <= 2'd0;
    end else if (w_scan_rise) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Slots 2 and 3 stay dark so each lit digit keeps a 1/4 duty cycle
  always_comb begin
    w_an  = 4'b1111;
    w_seg = 7'b1111111;
    case (r_idx)
      2'd0: begin
        w_an  = 4'b1110;
        w_seg = font(r_ones);
      end
      2'd1: begin
        w_an  = (LEAD_ZERO_BLANK && (r_tens == 4'd0)) ? 4'b1111 : 4'b1101;
        w_seg = font(r_tens);
      end
      default: begin
        w_an  = 4'b1111;
        w_seg = 7'b1111111;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_counter60_display.sv
`default_nettype none
// Self-checking bench for counter60_display: directed scenarios plus random
// stimulus compared cycle by cycle against an arithmetic reference model.
module tb_counter60_display;

  localparam int COUNT_MAX       = 59;
  localparam bit LEAD_ZERO_BLANK = 1'b0;

  logic       clk_50MHz = 1'b0;
  logic       rst       = 1'b1;
  logic       sec_in    = 1'b1;
  logic       scan_in   = 1'b1;
  logic       en        = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       wrap;

  int n_checks = 0;
  int n_bad    = 0;
  int n_wrap   = 0;

  // Reference model: count as a plain integer, display as a slot number
  int         m_count;
  int         m_idx;
  logic       m_sec_prev;
  logic       m_scan_prev;
  logic       m_wrap;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  logic [6:0] font_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  logic [3:0] hold_seq [4]  = '{4'b1101, 4'b1111, 4'b1111, 4'b1110};

  counter60_display #(
    .COUNT_MAX      (COUNT_MAX),
    .LEAD_ZERO_BLANK(LEAD_ZERO_BLANK)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .sec_in   (sec_in),
    .scan_in  (scan_in),
    .en       (en),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .wrap     (wrap)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock given the inputs seen at that edge
  task automatic model_update(input logic s, input logic c, input logic e, input logic r);
    if (r) begin
      m_count = 0; m_idx = 0; m_wrap = 1'b0;
      m_an = 4'b1111; m_seg = 7'b1111111;
      m_sec_prev = 1'b1; m_scan_prev = 1'b1;
    end else begin
      case (m_idx)
        0: begin m_an = 4'b1110; m_seg = font_tbl[m_count % 10]; end
        1: begin
          m_an  = (LEAD_ZERO_BLANK && (m_count / 10 == 0)) ? 4'b1111 : 4'b1101;
          m_seg = font_tbl[m_count / 10];
        end
        default: begin m_an = 4'b1111; m_seg = 7'b1111111; end
      endcase
      m_wrap = 1'b0;
      if (s && !m_sec_prev && e) begin
        if (m_count == COUNT_MAX) begin m_count = 0; m_wrap = 1'b1; end
        else m_count = m_count + 1;
      end
      if (c && !m_scan_prev) m_idx = (m_idx + 1) % 4;
      m_sec_prev  = s;
      m_scan_prev = c;
    end
  endtask

  task automatic step(input logic s, input logic c, input logic e, input logic r);
    sec_in = s; scan_in = c; en = e; rst = r;
    @(posedge clk_50MHz);
    model_update(s, c, e, r);
    #1;
    check_val("an", 32'(an), 32'(m_an));
    check_val("seg", 32'(seg), 32'(m_seg));
    check_val("dp", 32'(dp), 32'd1);
    check_val("wrap", 32'(wrap), 32'(m_wrap));
    if (wrap === 1'b1) n_wrap++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic sec_pulse(input logic e);
    step(1'b0, 1'b0, e, 1'b0);
    step(1'b1, 1'b0, e, 1'b0);
  endtask

  // Leaves the display registered on slot `target`
  task automatic scan_to(input int target);
    for (int i = 0; i < 4 && m_idx != target; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset with both inputs high: outputs dark while held
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_val("rst_an", 32'(an), 32'hF);
      check_val("rst_seg", 32'(seg), 32'h7F);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    scan_to(0);
    check_val("no_count_after_rst", 32'(seg), 32'(7'b1000000));
    sec_pulse(1'b1);
    scan_to(0);
    check_val("first_edge_counts", 32'(seg), 32'(7'b1111001));

    // Ten edges -> 10
    do_reset();
    for (int i = 0; i < 10; i++) sec_pulse(1'b1);
    scan_to(0);
    check_val("cnt10_ones", 32'(seg), 32'(7'b1000000));
    scan_to(1);
    check_val("cnt10_tens_an", 32'(an), 32'(4'b1101));
    check_val("cnt10_tens", 32'(seg), 32'(7'b1111001));

    // Sixty edges -> wrap pulse on the 60th only
    do_reset();
    n_wrap = 0;
    for (int i = 0; i < 59; i++) sec_pulse(1'b1);
    check_val("no_early_wrap", 32'(n_wrap), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("wrap_pulse", 32'(wrap), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_val("wrap_one_cycle", 32'(wrap), 32'd0);
    check_val("wrap_count", 32'(n_wrap), 32'd1);
    scan_to(0);
    check_val("wrap_ones0", 32'(seg), 32'(7'b1000000));
    scan_to(1);
    check_val("wrap_tens0", 32'(seg), 32'(7'b1000000));

    // Hold: en low drops edges, scanning carries on
    do_reset();
    for (int i = 0; i < 3; i++) sec_pulse(1'b1);
    for (int i = 0; i < 5; i++) sec_pulse(1'b0);
    scan_to(0);
    check_val("hold_an0", 32'(an), 32'(4'b1110));
    check_val("hold_value", 32'(seg), 32'(7'b0110000));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("hold_an_seq", 32'(an), 32'(hold_seq[i]));
    end

    // Collision at 09: both edges in one cycle
    do_reset();
    for (int i = 0; i < 9; i++) sec_pulse(1'b1);
    scan_to(0);
    check_val("coll_pre", 32'(seg), 32'(7'b0010000));
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("coll_an", 32'(an), 32'(4'b1101));
    check_val("coll_seg", 32'(seg), 32'(7'b1111001));

    // Reset mid-run at 37
    do_reset();
    for (int i = 0; i < 37; i++) sec_pulse(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("midrst_an", 32'(an), 32'hF);
    check_val("midrst_seg", 32'(seg), 32'h7F);
    check_val("midrst_wrap", 32'(wrap), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    scan_to(0);
    check_val("midrst_ones", 32'(seg), 32'(7'b1000000));
    scan_to(1);
    check_val("midrst_tens", 32'(seg), 32'(7'b1000000));

    // Random levels, enable and occasional reset against the model
    do_reset();
    begin
      logic s, c, e, r;
      s = 1'b1; c = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 2) == 0) s = ~s;
        if ($urandom_range(0, 3) == 0) c = ~c;
        e = ($urandom_range(0, 7) != 0);
        r = ($urandom_range(0, 499) == 0);
        step(s, c, e, r);
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
